// File: rtl/kamus_pkg.sv
// kamus_pkg: shared types and constants for the kamus-v front end.
//   instr_addr_state_t : control-unit PC source decision (PC_ST / J_ST / B_ST)
//   if_state_t         : instruction-fetch stage FSM states
//   KAMUS_NOP          : canonical NOP (addi x0,x0,0) used as the idle instruction
// Optional feature macro: KAMUS_IF_MISALIGN_CHECK_EN adds the IF_MISALIGN state.
package kamus_pkg;

    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] KAMUS_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_ST = 2'd0,
        J_ST  = 2'd1,
        B_ST  = 2'd2
    } instr_addr_state_t;

    typedef enum logic [2:0] {
        IF_IDLE     = 3'd0,
        IF_FETCH    = 3'd1,
        IF_WAIT     = 3'd2,
        IF_HOLD     = 3'd3,
        IF_DRAIN    = 3'd4
`ifdef KAMUS_IF_MISALIGN_CHECK_EN
        ,
        IF_MISALIGN = 3'd5
`endif
    } if_state_t;

endpackage

// File: rtl/kamus_if_stage_if.sv
// kamus_if_stage_if: bundles the fetch stage's instruction-memory port and its
// valid/ready delivery channel to decode.
//   master : the fetch stage (drives req/addr and the instruction output)
//   slave  : memory + decode side (drives gnt/rvalid/rdata and ready)
interface kamus_if_stage_if #(
    parameter int unsigned XLEN = 32
);
    import kamus_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;

    logic            instr_valid_o;
    logic [ILEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
    );

endinterface

// File: rtl/kamus_pc_gen.sv
// kamus_pc_gen: combinational next-PC selection for the fetch stage.
//   pc, redirect_valid, instr_addr_state, branch_taken, target_addr : inputs
//   redir_c    : a redirect happens this cycle
//   pc_seq_c   : sequential PC (pc + 4, modulo 2^XLEN)
//   pc_tgt_c   : redirect target with bit 0 cleared
//   misalign_c : redirect target has bit 1 set (only with KAMUS_IF_MISALIGN_CHECK_EN)
module kamus_pc_gen
    import kamus_pkg::*;
#(
    parameter int unsigned XLEN = 32
)(
    input  logic [XLEN-1:0]   pc,
    input  logic              redirect_valid,
    input  instr_addr_state_t instr_addr_state,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   target_addr,
    output logic              redir_c,
    output logic [XLEN-1:0]   pc_seq_c,
    output logic [XLEN-1:0]   pc_tgt_c,
    output logic              misalign_c
);

    // bit 0 of the target is always forced to zero, so it is never read
    logic unused_target_lsb;
    assign unused_target_lsb = target_addr[0];

    // redirect decision: jumps always, branches only when taken, PC_ST never
    always_comb begin
        redir_c = 1'b0;
        if (redirect_valid) begin
            case (instr_addr_state)
                J_ST:    redir_c = 1'b1;
                B_ST:    redir_c = branch_taken;
                default: redir_c = 1'b0;
            endcase
        end
    end

    assign pc_seq_c = pc + XLEN'(4);
    assign pc_tgt_c = {target_addr[XLEN-1:1], 1'b0};

`ifdef KAMUS_IF_MISALIGN_CHECK_EN
    assign misalign_c = redir_c & target_addr[1];
`else
    assign misalign_c = 1'b0;
`endif

endmodule

// File: rtl/kamus_if_stage.sv
// kamus_if_stage: instruction-fetch stage. Owns the PC, issues one outstanding
// request at a time to instruction memory and hands the fetched word plus its
// PC to decode over valid/ready. Redirects from execute override everything.
//   clk_i, rst_i (async, active-high)
//   redirect_valid_i, instr_addr_state_i, branch_taken_i, target_addr_i : redirect
//   bus (master)  : imem req/addr/gnt/rvalid/rdata and instr valid/data/pc/ready
//   misalign_o    : misaligned redirect target seen (KAMUS_IF_MISALIGN_CHECK_EN),
//                   otherwise tied 0
module kamus_if_stage
    import kamus_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR = '0
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redirect_valid_i,
    input  instr_addr_state_t instr_addr_state_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   target_addr_i,
    kamus_if_stage_if.master  bus,
    output logic              misalign_o
);

    if_state_t       state_q;
    logic [XLEN-1:0] pc_q;
    logic            req_q;
    logic            valid_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;

    logic            redir_c;
    logic [XLEN-1:0] pc_seq_c;
    logic [XLEN-1:0] pc_tgt_c;
    logic            misalign_c;

    kamus_pc_gen #(.XLEN(XLEN)) u_pc_gen (
        .pc               (pc_q),
        .redirect_valid   (redirect_valid_i),
        .instr_addr_state (instr_addr_state_i),
        .branch_taken     (branch_taken_i),
        .target_addr      (target_addr_i),
        .redir_c          (redir_c),
        .pc_seq_c         (pc_seq_c),
        .pc_tgt_c         (pc_tgt_c),
        .misalign_c       (misalign_c)
    );

`ifdef KAMUS_IF_MISALIGN_CHECK_EN
    logic misalign_q;
    assign misalign_o = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_c;
    assign misalign_o      = 1'b0;
`endif

    // fetch FSM; request, address and instruction outputs are all registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IF_IDLE;
            pc_q       <= BOOT_ADDR;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= KAMUS_NOP;
            instr_pc_q <= '0;
`ifdef KAMUS_IF_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else if (redir_c) begin
            pc_q    <= pc_tgt_c;
            valid_q <= 1'b0;
            // a response still owed by memory must be swallowed in DRAIN
            case (state_q)
                IF_FETCH: begin
                    state_q <= bus.imem_gnt_i ? IF_DRAIN : IF_FETCH;
                    req_q   <= ~bus.imem_gnt_i;
                end
                IF_WAIT, IF_DRAIN: begin
                    // a response arriving in the redirect cycle closes the
                    // outstanding request, so there is nothing left to drain
                    state_q <= bus.imem_rvalid_i ? IF_FETCH : IF_DRAIN;
                    req_q   <= bus.imem_rvalid_i;
                end
                default: begin
                    state_q <= IF_FETCH;
                    req_q   <= 1'b1;
                end
            endcase
`ifdef KAMUS_IF_MISALIGN_CHECK_EN
            misalign_q <= misalign_c;
            // misaligned target parks the stage; any in-flight response is ignored
            if (misalign_c) begin
                state_q <= IF_MISALIGN;
                req_q   <= 1'b0;
            end
`endif
        end else begin
            case (state_q)
                IF_IDLE: begin
                    state_q <= IF_FETCH;
                    req_q   <= 1'b1;
                end
                IF_FETCH: begin
                    if (bus.imem_gnt_i) begin
                        state_q <= IF_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                IF_WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        instr_q    <= bus.imem_rdata_i;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_seq_c;
                        state_q    <= IF_HOLD;
                    end
                end
                IF_HOLD: begin
                    if (bus.instr_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IF_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                IF_DRAIN: begin
                    if (bus.imem_rvalid_i) begin
                        state_q <= IF_FETCH;
                        req_q   <= 1'b1;
                    end
                end
`ifdef KAMUS_IF_MISALIGN_CHECK_EN
                IF_MISALIGN: begin
                    state_q <= IF_MISALIGN;
                    req_q   <= 1'b0;
                end
`endif
                default: begin
                    state_q <= IF_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_o    = req_q;
    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.instr_o       = instr_q;
    assign bus.instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_kamus_if_stage.sv
// Testbench for kamus_if_stage: memory responder with programmable stall and
// response latency, expectation queues filled by the stimulus, and a monitor
// that pops and compares on every granted request and every accepted instruction.
`timescale 1ns/1ps
module tb_kamus_if_stage;
    import kamus_pkg::*;

    localparam int unsigned     XLEN = 32;
    localparam logic [XLEN-1:0] BOOT = 32'h0000_0100;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              redirect_valid_i;
    instr_addr_state_t instr_addr_state_i;
    logic              branch_taken_i;
    logic [XLEN-1:0]   target_addr_i;
    logic              misalign_o;

    kamus_if_stage_if #(.XLEN(XLEN)) bus ();

    kamus_if_stage #(.XLEN(XLEN), .BOOT_ADDR(BOOT)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .redirect_valid_i   (redirect_valid_i),
        .instr_addr_state_i (instr_addr_state_i),
        .branch_taken_i     (branch_taken_i),
        .target_addr_i      (target_addr_i),
        .bus                (bus),
        .misalign_o         (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];

    // responder knobs
    int          rv_delay   = 1;
    bit          gnt_en     = 1'b1;
    logic [31:0] stall_addr = 32'h0000_0104;
    int          stall_left = 3;
    int          pend_cnt   = 0;
    logic [31:0] pend_addr  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk_i);
        #1;
    endtask

    task automatic drive_redirect(input instr_addr_state_t st, input logic tk, input logic [31:0] tgt);
        @(posedge clk_i); #1;
        redirect_valid_i   = 1'b1;
        instr_addr_state_i = st;
        branch_taken_i     = tk;
        target_addr_i      = tgt;
        @(posedge clk_i); #1;
        redirect_valid_i   = 1'b0;
        instr_addr_state_i = PC_ST;
        branch_taken_i     = 1'b0;
    endtask

    task automatic wait_req_addr(input logic [31:0] a, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nclk();
            if (bus.imem_req_o && bus.imem_addr_o == a) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_req_addr_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nclk();
            if (bus.instr_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_valid_seen", 32'(seen), 32'd1);
    endtask

    // wait for a grant, then stop granting so the next fetch parks in FETCH
    task automatic wait_gnt(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nclk();
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                seen = 1'b1;
                break;
            end
        end
        gnt_en = 1'b0;
        chk("wait_gnt_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_empty(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            nclk();
            if (exp_pc_q.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_delivered", 32'(seen), 32'd1);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_addr_q.push_back(a);
        exp_pc_q.push_back(a);
        exp_instr_q.push_back({16'hC0DE, a[15:0]});
    endtask

    // instruction memory: stalls grants for stall_addr, answers rv_delay cycles after grant
    always begin
        @(posedge clk_i); #1;
        if (rst_i) begin
            pend_cnt          = 0;
            bus.imem_gnt_i    = 1'b0;
            bus.imem_rvalid_i = 1'b0;
        end else begin
            bus.imem_rvalid_i = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = {16'hC0DE, pend_addr[15:0]};
                end
            end
            if (bus.imem_req_o && bus.imem_addr_o == stall_addr && stall_left > 0) begin
                bus.imem_gnt_i = 1'b0;
                stall_left--;
            end else begin
                bus.imem_gnt_i = bus.imem_req_o && gnt_en;
                if (bus.imem_gnt_i) begin
                    pend_cnt  = rv_delay;
                    pend_addr = bus.imem_addr_o;
                end
            end
        end
    end

    // monitor: compares granted request addresses and accepted instructions
    always @(negedge clk_i) begin
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        if (!rst_i) begin
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_addr unexpected request actual=%h expected=none", bus.imem_addr_o);
                end else begin
                    e_addr = exp_addr_q.pop_front();
                    if (bus.imem_addr_o !== e_addr) begin
                        errors++;
                        $display("FAIL req_addr actual=%h expected=%h", bus.imem_addr_o, e_addr);
                    end
                end
            end
            if (bus.instr_valid_o && bus.instr_ready_i) begin
                checks++;
                if (exp_pc_q.size() == 0) begin
                    errors++;
                    $display("FAIL instr unexpected delivery actual pc=%h instr=%h expected=none",
                             bus.instr_pc_o, bus.instr_o);
                end else begin
                    e_pc    = exp_pc_q.pop_front();
                    e_instr = exp_instr_q.pop_front();
                    if (bus.instr_pc_o !== e_pc || bus.instr_o !== e_instr) begin
                        errors++;
                        $display("FAIL instr actual pc=%h instr=%h expected pc=%h instr=%h",
                                 bus.instr_pc_o, bus.instr_o, e_pc, e_instr);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i              = 1'b1;
        redirect_valid_i   = 1'b0;
        instr_addr_state_i = PC_ST;
        branch_taken_i     = 1'b0;
        target_addr_i      = '0;
        bus.instr_ready_i  = 1'b1;
        bus.imem_gnt_i     = 1'b0;
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i   = '0;

        push_fetch(32'h0000_0100);
        push_fetch(32'h0000_0104);
        push_fetch(32'h0000_0108);

        // reset values
        nclk(); nclk();
        chk("rst_req",      32'(bus.imem_req_o),    32'd0);
        chk("rst_valid",    32'(bus.instr_valid_o), 32'd0);
        chk("rst_instr",    bus.instr_o,            32'h0000_0013);
        chk("rst_instr_pc", bus.instr_pc_o,         32'h0);
        chk("rst_addr",     bus.imem_addr_o,        32'h0000_0100);
        chk("rst_misalign", 32'(misalign_o),        32'd0);

        @(posedge clk_i); #1;
        rst_i = 1'b0;
        nclk();
        chk("first_req_idle", 32'(bus.imem_req_o), 32'd0);
        nclk();
        chk("first_req",      32'(bus.imem_req_o), 32'd1);
        chk("first_addr",     bus.imem_addr_o,     32'h0000_0100);

        // grant withheld for 3 cycles at 0x104
        wait_req_addr(32'h0000_0104, 40);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) nclk();
            chk("stall_req",  32'(bus.imem_req_o), 32'd1);
            chk("stall_addr", bus.imem_addr_o,     32'h0000_0104);
            chk("stall_gnt",  32'(bus.imem_gnt_i), 32'd0);
        end

        // decode back-pressure for 4 cycles on the 0x108 instruction
        wait_req_addr(32'h0000_0108, 40);
        @(posedge clk_i); #1;
        bus.instr_ready_i = 1'b0;
        wait_valid(10);
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nclk();
            chk("hold_valid",    32'(bus.instr_valid_o), 32'd1);
            chk("hold_instr",    bus.instr_o,            32'hC0DE_0108);
            chk("hold_instr_pc", bus.instr_pc_o,         32'h0000_0108);
            chk("hold_no_req",   32'(bus.imem_req_o),    32'd0);
        end
        @(posedge clk_i); #1;
        bus.instr_ready_i = 1'b1;
        nclk();
        nclk();
        chk("park_addr_10c", bus.imem_addr_o,     32'h0000_010C);
        chk("park_req_10c",  32'(bus.imem_req_o), 32'd1);

        // J_ST redirect to 0x203 while waiting; stale 0x10C word arrives 2 cycles later
        rv_delay = 3;
        gnt_en   = 1'b1;
        exp_addr_q.push_back(32'h0000_010C);
        nclk();
        chk("stale_gnt", 32'(bus.imem_gnt_i), 32'd1);
        drive_redirect(J_ST, 1'b0, 32'h0000_0203);
        nclk();
        chk("drain_req",   32'(bus.imem_req_o),    32'd0);
        chk("drain_valid", 32'(bus.instr_valid_o), 32'd0);
        rv_delay = 1;
        push_fetch(32'h0000_0202);
        nclk();
        chk("drain_req2", 32'(bus.imem_req_o), 32'd0);
        nclk();
        chk("redir_req",  32'(bus.imem_req_o), 32'd1);
        chk("redir_addr", bus.imem_addr_o,     32'h0000_0202);
        gnt_en = 1'b0;
        wait_empty(20);
        nclk();
        chk("seq_after_redir", bus.imem_addr_o, 32'h0000_0206);

        // not-taken branch and PC_ST with redirect_valid must not move the PC
        drive_redirect(B_ST, 1'b0, 32'h0000_0300);
        nclk();
        chk("b_not_taken_addr", bus.imem_addr_o, 32'h0000_0206);
        drive_redirect(PC_ST, 1'b1, 32'h0000_0300);
        nclk();
        chk("pc_st_addr", bus.imem_addr_o,     32'h0000_0206);
        chk("pc_st_req",  32'(bus.imem_req_o), 32'd1);

        // taken branch while waiting for grant: new address in FETCH, bit 0 cleared
        drive_redirect(B_ST, 1'b1, 32'h0000_0301);
        nclk();
        chk("b_taken_addr", bus.imem_addr_o,     32'h0000_0300);
        chk("b_taken_req",  32'(bus.imem_req_o), 32'd1);
        push_fetch(32'h0000_0300);
        gnt_en = 1'b1;
        wait_gnt(10);
        wait_empty(20);
        nclk();
        chk("seq_304", bus.imem_addr_o, 32'h0000_0304);

        // PC wrap at the top of the address space
        drive_redirect(J_ST, 1'b0, 32'hFFFF_FFFC);
        nclk();
        chk("wrap_tgt", bus.imem_addr_o, 32'hFFFF_FFFC);
        push_fetch(32'hFFFF_FFFC);
        gnt_en = 1'b1;
        wait_gnt(10);
        wait_empty(20);
        nclk();
        chk("wrap_addr", bus.imem_addr_o,     32'h0000_0000);
        chk("wrap_req",  32'(bus.imem_req_o), 32'd1);

`ifdef KAMUS_IF_MISALIGN_CHECK_EN
        drive_redirect(J_ST, 1'b0, 32'h0000_0402);
        nclk();
        chk("misalign_set",   32'(misalign_o),        32'd1);
        chk("misalign_req",   32'(bus.imem_req_o),    32'd0);
        chk("misalign_valid", 32'(bus.instr_valid_o), 32'd0);
        nclk(); nclk(); nclk();
        chk("misalign_held",     32'(misalign_o),     32'd1);
        chk("misalign_req_held", 32'(bus.imem_req_o), 32'd0);
        drive_redirect(J_ST, 1'b0, 32'h0000_0400);
        nclk();
        chk("realign_clear", 32'(misalign_o),        32'd0);
        chk("realign_req",   32'(bus.imem_req_o),    32'd1);
        chk("realign_addr",  bus.imem_addr_o,        32'h0000_0400);
        push_fetch(32'h0000_0400);
`else
        drive_redirect(J_ST, 1'b0, 32'h0000_0402);
        nclk();
        chk("nocheck_misalign", 32'(misalign_o),     32'd0);
        chk("nocheck_req",      32'(bus.imem_req_o), 32'd1);
        chk("nocheck_addr",     bus.imem_addr_o,     32'h0000_0402);
        push_fetch(32'h0000_0402);
`endif
        gnt_en = 1'b1;
        wait_gnt(10);
        wait_empty(20);

        chk("addr_queue_empty",  32'(exp_addr_q.size()), 32'd0);
        chk("instr_queue_empty", 32'(exp_pc_q.size()),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
